// File: rtl/ram_loader.sv
// Framed byte-stream loader: address, length, payload, checksum.
// Owns the RAM port while loading; passes the CPU bus through when idle.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_start                   begin a frame (only honoured in IDLE)
//   i_byte, i_valid, o_ready  stream byte handshake
//   i_cpu_addr/data/we        CPU RAM bus (used while idle)
//   o_ram_addr/data/we        RAM port
//   o_busy                    loader owns the RAM bus
//   or_done                   one-cycle pulse at end of frame
//   or_err                    checksum mismatch, sticky until next start
module ram_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_byte,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_data,
  input  logic                  i_cpu_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  output logic                  o_busy,
  output logic                  or_done,
  output logic                  or_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_we_q, wr_we_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  acc;

  assign o_ready = (state_q != S_IDLE);
  assign o_busy  = (state_q != S_IDLE);
  assign acc     = i_valid && o_ready;
  assign or_done = done_q;
  assign or_err  = err_q;

  assign o_ram_addr = o_busy ? wr_addr_q : i_cpu_addr;
  assign o_ram_data = o_busy ? wr_data_q : i_cpu_data;
  assign o_ram_we   = o_busy ? wr_we_q   : i_cpu_we;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_we_d   = 1'b0;
    sum_d     = sum_q;
    count_d   = count_q;
    done_d    = 1'b0;
    err_d     = err_q;

    // Advance the pointer once the pending write has been presented.
    if (wr_we_q) wr_addr_d = wr_addr_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_ADDR;
          err_d   = 1'b0;
          sum_d   = '0;
        end
      end
      S_ADDR: begin
        if (acc) begin
          wr_addr_d = i_byte[ADDR_WIDTH-1:0];
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        if (acc) begin
          count_d = i_byte;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (acc) begin
          wr_data_d = i_byte;
          wr_we_d   = 1'b1;
          sum_d     = sum_q + i_byte;
          // Length 0 wraps through FF..1, giving 2^DATA_WIDTH bytes.
          count_d   = count_q - 1'b1;
          if (count_q == DATA_WIDTH'(1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (acc) begin
          err_d   = (i_byte != sum_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_we_q   <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_we_q   <= wr_we_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: randomized frames against a
// frame-level reference, with a behavioural RAM on the port.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byt = '0;
  logic       valid = 1'b0;
  logic       ready;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_data = '0;
  logic       cpu_we = 1'b0;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       busy;
  logic       done;
  logic       err;

  ram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_byte     (byt),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_cpu_addr (cpu_addr),
    .i_cpu_data (cpu_data),
    .i_cpu_we   (cpu_we),
    .o_ram_addr (ram_addr),
    .o_ram_data (ram_data),
    .o_ram_we   (ram_we),
    .o_busy     (busy),
    .or_done    (done),
    .or_err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_q;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    rd_q <= mem[ram_addr];
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t wq[$];
  bit  dq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1 && ram_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_write got %0h/%0h want none",
                 ram_addr, ram_data);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", ram_addr, e.a);
        chk("wr_data", ram_data, e.d);
        chk("wr_cycle", cyc, e.c);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_done got 1 want 0");
      end else begin
        bit e;
        e = dq.pop_front();
        chk("err_at_done", err, e);
      end
    end
  end

  task automatic put(input logic [7:0] b, input bit stall,
                     input bit is_data, input logic [7:0] a);
    if (stall && $urandom_range(0, 1) == 1) begin
      valid = 1'b0;
      @(negedge clk);
    end
    chk("ready", ready, 1);
    valid = 1'b1;
    byt   = b;
    start = 1'($urandom_range(0, 1));
    if (is_data) begin
      wq.push_back('{a: a, d: b, c: cyc + 1});
      ref_mem[a] = b;
    end
    @(negedge clk);
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] len,
                       input logic [7:0] d[$], input logic [7:0] cs,
                       input bit stall);
    logic [7:0] s;
    int t;
    s = '0;
    foreach (d[i]) s = s + d[i];
    dq.push_back(cs != s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", busy, 1);
    chk("err_cleared", err, 0);
    cpu_we   = 1'b1;
    cpu_addr = 8'($urandom);
    cpu_data = 8'($urandom);
    put(a, stall, 1'b0, 8'h0);
    put(len, stall, 1'b0, 8'h0);
    foreach (d[i]) put(d[i], stall, 1'b1, a + 8'(i));
    put(cs, stall, 1'b0, 8'h0);
    cpu_we = 1'b0;
    t = 0;
    while (dq.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got none want pulse");
      dq.delete();
    end
    chk("busy_end", busy, 0);
    chk("writes_left", wq.size(), 0);
    wq.delete();
    chk("err_sticky", err, 32'(cs != s));
  endtask

  task automatic rd(input logic [7:0] a);
    cpu_we   = 1'b0;
    cpu_addr = a;
    @(negedge clk);
    chk("readback", rd_q, ref_mem[a]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] a, s;
    int n;
    for (int k = 0; k < 256; k++) begin
      mem[k]     = '0;
      ref_mem[k] = '0;
    end
    cpu_addr = 8'd5;
    cpu_data = 8'd7;
    cpu_we   = 1'b1;
    ref_mem[5] = 8'd7;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", ram_addr, 5);
    chk("rst_data", ram_data, 7);
    chk("rst_we", ram_we, 1);
    rst_n  = 1'b1;
    cpu_we = 1'b0;
    @(negedge clk);

    frame(8'h03, 8'h03, '{8'h0B, 8'h16, 8'h21}, 8'h42, 1'b0);
    for (int k = 3; k < 6; k++) rd(8'(k));

    frame(8'h03, 8'h03, '{8'h0B, 8'h16, 8'h21}, 8'h3D, 1'b0);
    repeat (4) @(negedge clk);
    chk("err_hold", err, 1);

    frame(8'hFE, 8'h03, '{8'h01, 8'h02, 8'h03}, 8'h06, 1'b0);
    rd(8'hFE);
    rd(8'hFF);
    rd(8'h00);

    q.delete();
    for (int k = 0; k < 256; k++) q.push_back(8'(k));
    frame(8'h00, 8'h00, q, 8'h80, 1'b1);
    for (int k = 0; k < 256; k++) rd(8'(k));

    for (int f = 0; f < 6; f++) begin
      q.delete();
      n = $urandom_range(1, 8);
      s = '0;
      for (int k = 0; k < n; k++) begin
        q.push_back(8'($urandom));
        s = s + q[k];
      end
      a = 8'($urandom);
      if ($urandom_range(0, 2) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
      frame(a, 8'(n), q, s, 1'b1);
      for (int k = 0; k < n; k++) rd(a + 8'(k));
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    put(8'h40, 1'b0, 1'b0, 8'h0);
    put(8'h05, 1'b0, 1'b0, 8'h0);
    put(8'hA1, 1'b0, 1'b1, 8'h40);
    put(8'hB2, 1'b0, 1'b1, 8'h41);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_writes", wq.size(), 0);
    wq.delete();
    rd(8'h40);
    rd(8'h41);
    rd(8'h42);

    frame(8'h90, 8'h02, '{8'h11, 8'h22}, 8'h33, 1'b1);
    rd(8'h90);
    rd(8'h91);

    repeat (3) @(negedge clk);
    chk("final_writes", wq.size(), 0);
    chk("final_done", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
